// File: rtl/ab_pattern_pkg.sv
// ab_pattern_pkg: shared definitions for the A/B pattern transmitter.
//   - state_t      : FSM state codes exported on SP/SF
//   - SYM_W        : width of one {A,B} symbol
//   - clamp_len_w  : width of a length value that can hold 0..DEPTH
package ab_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int SYM_W = 2;

    // One extra bit over the slot index so the value DEPTH itself fits.
    function automatic int clamp_len_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ab_pattern_mem.sv
// ab_pattern_mem: DEPTH x SYM_W pattern register file.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (clears all slots)
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_addr/rd_data : combinational read port
module ab_pattern_mem
    import ab_pattern_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SYM_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [SYM_W-1:0]         rd_data
);

    logic [SYM_W-1:0] mem_r [DEPTH];

    // Slot storage: cleared on reset, written one slot per clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {SYM_W{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ab_pattern_tx.sv
// ab_pattern_tx: plays a programmed sequence of {A,B} symbols, each held for
// a configurable number of clocks, optionally looping with a one-cycle gap.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : pattern slot write (honoured only in IDLE)
//   len, hold, loop   : pass length, clocks per symbol, repeat flag (captured at start)
//   start, stop       : one-cycle start strobe, abort request (stop wins)
//   A, B              : symbol output (00 outside EMIT)
//   busy, done        : high in EMIT/GAP, one-cycle pulse in DONE
//   SP, SF            : present state code, next state code (combinational)
module ab_pattern_tx
    import ab_pattern_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SYM_W-1:0]         wr_data,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic [HOLD_W-1:0]        hold,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    output logic                     A,
    output logic                     B,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               SP,
    output logic [1:0]               SF
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = clamp_len_w(DEPTH);

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  idx_r, idx_s;
    logic [HOLD_W-1:0]  cnt_r, cnt_s;
    logic [SYM_W-1:0]   sym_r, sym_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [HOLD_W-1:0]  hold_r, hold_s;
    logic               loop_r, loop_s;
    logic [SYM_W-1:0]   ab_r, ab_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    logic [LEN_W-1:0]   len_clamp_s;
    logic [HOLD_W-1:0]  hold_clamp_s;
    logic               last_s;
    logic               adv_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [SYM_W-1:0]   rd_data_s;
    logic               mem_we_s;

    assign len_clamp_s  = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign hold_clamp_s = (hold == {HOLD_W{1'b0}}) ? HOLD_W'(1) : hold;
    assign last_s       = ({1'b0, idx_r} == (len_r - LEN_W'(1)));
    assign adv_s        = (state_r == ST_EMIT) && (cnt_r == {HOLD_W{1'b0}}) && !last_s;
    assign mem_we_s     = wr_en && (state_r == ST_IDLE);

    ab_pattern_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_we_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Read address: the next slot when advancing within a pass, else slot 0
    // (the slot needed on start and when leaving GAP).
    always_comb begin
        rd_addr_s = {ADDR_W{1'b0}};
        if (adv_s) begin
            rd_addr_s = idx_r + ADDR_W'(1);
        end else begin
            rd_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Next-state and next-datapath computation; also drives SF.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        sym_s   = sym_r;
        len_s   = len_r;
        hold_s  = hold_r;
        loop_s  = loop_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop && (len != {LEN_W{1'b0}})) begin
                    state_s = ST_EMIT;
                    len_s   = len_clamp_s;
                    hold_s  = hold_clamp_s;
                    loop_s  = loop;
                    idx_s   = {ADDR_W{1'b0}};
                    sym_s   = rd_data_s;
                    cnt_s   = hold_clamp_s - HOLD_W'(1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (cnt_r != {HOLD_W{1'b0}}) begin
                    cnt_s = cnt_r - HOLD_W'(1);
                end else if (!last_s) begin
                    idx_s = idx_r + ADDR_W'(1);
                    sym_s = rd_data_s;
                    cnt_s = hold_r - HOLD_W'(1);
                end else if (loop_r) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EMIT;
                    idx_s   = {ADDR_W{1'b0}};
                    sym_s   = rd_data_s;
                    cnt_s   = hold_r - HOLD_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the state about to be entered, so the outputs can be
    // registered without adding a cycle of latency.
    always_comb begin
        ab_s   = (state_s == ST_EMIT) ? sym_s : {SYM_W{1'b0}};
        busy_s = (state_s == ST_EMIT) || (state_s == ST_GAP);
        done_s = (state_s == ST_DONE);
    end

    // FSM state, counters, captured configuration and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= {ADDR_W{1'b0}};
            cnt_r   <= {HOLD_W{1'b0}};
            sym_r   <= {SYM_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            loop_r  <= 1'b0;
            ab_r    <= {SYM_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            sym_r   <= sym_s;
            len_r   <= len_s;
            hold_r  <= hold_s;
            loop_r  <= loop_s;
            ab_r    <= ab_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign A    = ab_r[1];
    assign B    = ab_r[0];
    assign busy = busy_r;
    assign done = done_r;
    assign SP   = state_r;
    assign SF   = state_s;

endmodule

// File: tb/tb_ab_pattern_tx.sv
// tb_ab_pattern_tx: self-checking bench for ab_pattern_tx (DEPTH=8, HOLD_W=4).
// The expected waveform of a transmission is built as a list of per-cycle
// observations from the pattern contents and the len/hold/loop rules.
module tb_ab_pattern_tx;

    localparam logic [1:0] S_I = 2'b00;
    localparam logic [1:0] S_E = 2'b01;
    localparam logic [1:0] S_G = 2'b10;
    localparam logic [1:0] S_D = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [1:0] wr_data;
    logic [3:0] len;
    logic [3:0] hold;
    logic       loop;
    logic       start;
    logic       stop;
    logic       a_o, b_o, busy, done;
    logic [1:0] sp, sf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] ab;
        logic       busy;
        logic       done;
        logic [1:0] sp;
    } obs_t;

    typedef struct {
        int len;
        int hold;
        bit lp;
        int stop_at;
        bit disturb;
    } vec_t;

    obs_t       exp_q[$];
    logic [1:0] mdl_mem [8];
    vec_t       vecs [6];

    ab_pattern_tx #(.DEPTH(8), .HOLD_W(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .len(len), .hold(hold), .loop(loop),
        .start(start), .stop(stop), .A(a_o), .B(b_o), .busy(busy),
        .done(done), .SP(sp), .SF(sf)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [1:0] ab, input logic bz, input logic dn, input logic [1:0] st);
        obs_t o;
        o.ab = ab; o.busy = bz; o.done = dn; o.sp = st;
        return o;
    endfunction

    // Expected per-cycle observations starting the cycle after start.
    // Returns the stop cycle index actually applied (-1 = none).
    function automatic int build(input int len_i, input int hold_i, input bit lp, input int stop_req);
        int le, he, st, sr;
        le = (len_i > 8) ? 8 : len_i;
        he = (hold_i == 0) ? 1 : hold_i;
        sr = (lp && stop_req < 0) ? 0 : stop_req;
        exp_q.delete();
        do begin
            for (int i = 0; i < le; i++)
                for (int h = 0; h < he; h++)
                    exp_q.push_back(mk(mdl_mem[i], 1'b1, 1'b0, S_E));
            if (lp) exp_q.push_back(mk(2'b00, 1'b1, 1'b0, S_G));
        end while (lp && exp_q.size() <= sr);
        if (!lp) exp_q.push_back(mk(2'b00, 1'b0, 1'b1, S_D));
        st = -1;
        if (sr >= 0 && sr < exp_q.size() && exp_q[sr].busy) begin
            st = sr;
            while (exp_q.size() > st + 1) void'(exp_q.pop_back());
        end
        exp_q.push_back(mk(2'b00, 1'b0, 1'b0, S_I));
        return st;
    endfunction

    task automatic chk(input string nm, input obs_t e, input logic [1:0] esf);
        logic [7:0] got, want;
        got  = {a_o, b_o, busy, done, sp, sf};
        want = {e.ab, e.busy, e.done, e.sp, esf};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: A,B,busy,done,SP,SF got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic load(input int addr, input logic [1:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr[2:0]; wr_data = data;
        mdl_mem[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input string nm, input int len_i, input int hold_i, input bit lp,
                       input int stop_req, input bit disturb);
        int stop_at;
        logic [1:0] esf;
        logic [3:0] l4, h4;
        stop_at = build(len_i, hold_i, lp, stop_req);
        l4 = len_i[3:0]; h4 = hold_i[3:0];
        @(negedge clk);
        len = l4; hold = h4; loop = lp; start = 1'b1; stop = 1'b0;
        #1;
        chk($sformatf("%s_go", nm), mk(2'b00, 1'b0, 1'b0, S_I), exp_q[0].sp);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            start   = disturb && exp_q[k].busy;
            wr_en   = disturb && exp_q[k].busy;
            wr_addr = 3'd0;
            wr_data = 2'($urandom);
            stop    = (k == stop_at);
            len     = 4'($urandom);
            hold    = 4'($urandom);
            loop    = 1'($urandom);
            #1;
            if (k == stop_at)            esf = S_I;
            else if (k + 1 < exp_q.size()) esf = exp_q[k + 1].sp;
            else                          esf = S_I;
            chk($sformatf("%s[%0d]", nm, k), exp_q[k], esf);
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; stop = 1'b0; loop = 1'b0;
    endtask

    // Single-cycle IDLE request that must not leave IDLE.
    task automatic idle_req(input string nm, input logic [3:0] l, input logic st, input logic sp_in);
        @(negedge clk);
        len = l; hold = 4'd1; loop = 1'b0; start = st; stop = sp_in;
        #1;
        chk({nm, "_sf"}, mk(2'b00, 1'b0, 1'b0, S_I), S_I);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #1;
        chk({nm, "_after"}, mk(2'b00, 1'b0, 1'b0, S_I), S_I);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 2'd0;
        len = 4'd0; hold = 4'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 8; i++) mdl_mem[i] = 2'b00;

        // Reset and idle
        repeat (2) @(negedge clk);
        #1;
        chk("reset", mk(2'b00, 1'b0, 1'b0, S_I), S_I);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("idle", mk(2'b00, 1'b0, 1'b0, S_I), S_I);
        run("zero_slots", 8, 1, 1'b0, -1, 1'b0);

        // Directed multi-cycle sequences
        load(0, 2'b01); load(1, 2'b10); load(2, 2'b11); load(3, 2'b00);
        run("single", 4, 2, 1'b0, -1, 1'b0);
        run("clamp", 12, 0, 1'b0, -1, 1'b0);
        load(0, 2'b10); load(1, 2'b01);
        run("loop_stop", 2, 1, 1'b1, 4, 1'b0);
        idle_req("start_stop", 4'd4, 1'b1, 1'b1);
        idle_req("len_zero", 4'd0, 1'b1, 1'b0);

        // Table of vectors, run back to back on one random pattern so that
        // any honoured write during a disturbed run shows up later.
        vecs[0] = '{len: 3, hold: 3, lp: 1'b0, stop_at: -1, disturb: 1'b1};
        vecs[1] = '{len: 8, hold: 15, lp: 1'b0, stop_at: -1, disturb: 1'b0};
        vecs[2] = '{len: 1, hold: 1, lp: 1'b0, stop_at: -1, disturb: 1'b1};
        vecs[3] = '{len: 5, hold: 2, lp: 1'b1, stop_at: 11, disturb: 1'b1};
        vecs[4] = '{len: 15, hold: 1, lp: 1'b1, stop_at: 8, disturb: 1'b0};
        vecs[5] = '{len: 6, hold: 4, lp: 1'b0, stop_at: 9, disturb: 1'b1};
        for (int i = 0; i < 8; i++) load(i, 2'($urandom));
        for (int v = 0; v < 6; v++)
            run($sformatf("vec%0d", v), vecs[v].len, vecs[v].hold, vecs[v].lp,
                vecs[v].stop_at, vecs[v].disturb);

        // Randomized vectors
        for (int r = 0; r < 12; r++) begin
            int rl, rh, rs;
            bit rlp;
            if (r % 4 == 0)
                for (int i = 0; i < 8; i++) load(i, 2'($urandom));
            rl  = $urandom_range(1, 15);
            rh  = $urandom_range(0, 15);
            rlp = 1'($urandom_range(0, 1));
            if (rlp)                            rs = $urandom_range(0, 40);
            else if ($urandom_range(0, 2) == 0) rs = $urandom_range(0, 20);
            else                                rs = -1;
            run($sformatf("rnd%0d", r), rl, rh, rlp, rs, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of EMIT
        for (int i = 0; i < 8; i++) load(i, 2'b11);
        @(negedge clk);
        len = 4'd8; hold = 4'd4; loop = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst", mk(2'b11, 1'b1, 1'b0, S_E), S_E);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst", mk(2'b00, 1'b0, 1'b0, S_I), S_I);
        @(negedge clk);
        #1;
        chk("rst_hold", mk(2'b00, 1'b0, 1'b0, S_I), S_I);
        reset = 1'b1;
        loop = 1'b0;
        for (int i = 0; i < 8; i++) mdl_mem[i] = 2'b00;
        @(negedge clk);
        #1;
        chk("rst_idle", mk(2'b00, 1'b0, 1'b0, S_I), S_I);
        run("slots_cleared", 8, 1, 1'b0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ab_pattern_tx.md
Name: ab_pattern_tx

Overview:
Transmit-side counterpart of the lab's A/B-input Moore FSMs: plays a programmed sequence of 2-bit symbols onto the A and B lines, one symbol per configurable number of clocks. The sequence is loaded through a small write port and started or stopped by single-cycle strobes. Present and next state codes are exported as SP/SF for lab observation. Sits beside a detector FSM on the same clk, replacing hand-written stimulus.

Parameters:
DEPTH, 8, number of pattern slots (power of 2, ≥2)
HOLD_W, 4, width of the per-symbol hold count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write pattern slot; honoured only in IDLE
wr_addr  in  $clog2(DEPTH)  slot index
wr_data  in  2  symbol {A,B}
len  in  $clog2(DEPTH)+1  symbols per pass; 0 = no-op, values >DEPTH clamp to DEPTH
hold  in  HOLD_W  clocks per symbol; 0 treated as 1
loop  in  1  repeat the pattern until stopped
start  in  1  begin transmission (one-cycle strobe)
stop  in  1  abort transmission
A  out  1  symbol bit 1
B  out  1  symbol bit 0
busy  out  1  high in EMIT and GAP
done  out  1  one-cycle pulse in DONE
SP  out  2  present state code
SF  out  2  next state code (combinational)

Behaviour:
- States and codes: IDLE=00, EMIT=01, GAP=10, DONE=11.
- Reset (reset=0, asynchronous): state IDLE; all pattern slots 00; idx, count, and the captured len/hold/loop cleared; A=B=0; busy=0; done=0; SP=00. SF=00 while start=0.
- Outputs:
  - {A,B} = sym_q in EMIT, otherwise 00.
  - busy = (state==EMIT or GAP).
  - done = (state==DONE).
- IDLE:
  - wr_en writes mem[wr_addr] <= wr_data at the edge.
  - start=1, stop=0, len≠0 → EMIT. At that edge, capture len_eff=min(len,DEPTH), hold_eff=max(hold,1) and loop; set idx=0, sym_q=mem[0] and cnt=hold_eff-1.
  - start with len=0 stays in IDLE.
  - start and stop together stay in IDLE (stop wins).
  - Latency: first symbol appears on A/B in the cycle after start is sampled.
- EMIT: each symbol is held exactly hold_eff cycles.
  - cnt≠0 → cnt-1.
  - cnt=0 and idx<len_eff-1 → idx+1, sym_q=mem[idx+1], cnt=hold_eff-1; stay in EMIT.
  - cnt=0 and idx=len_eff-1 and loop=1 → GAP.
  - cnt=0 and idx=len_eff-1 and loop=0 → DONE.
- GAP: A=B=0 for exactly one cycle, then EMIT with idx=0, sym_q=mem[0], cnt=hold_eff-1.
- DONE: one cycle with done=1 and A=B=0, then IDLE. A start sampled in DONE is ignored.
- stop sampled in EMIT or GAP → IDLE at the next edge; A=B=0 from then on; no done pulse.
- While busy:
  - start and wr_en are ignored.
  - Changes to len, hold and loop have no effect until the next start.
- Reset asserted mid-transmission forces IDLE and 00 outputs immediately; no done pulse is produced.
- SF always equals the state the next edge will load, given the current inputs, including the stop and start cases.

Decomposition:
- Shared package holds:
  - state codes ST_IDLE/ST_EMIT/ST_GAP/ST_DONE;
  - symbol width SYM_W=2;
  - helper constant for the clamped length width.
- One natural sub-module, ab_pattern_mem: a DEPTH×2 register file with async-low reset, a synchronous write port and a combinational read port.
- The FSM, counters and output logic stay in ab_pattern_tx.

Test Plan:
- Reset then idle: pulse reset low, hold inputs at 0 → A=B=0, busy=0, done=0, SP=SF=00, and all slots read 00.
- Single pass: load slots 0..3 with 01,10,11,00, len=4, hold=2, loop=0, then pulse start → A/B show 01,01,10,10,11,11,00,00 from the cycle after start; DONE lasts one cycle with done=1; then SP=00.
- hold=0 and clamping: len=12, hold=0, DEPTH=8 → 8 symbols, one cycle each; busy is high for exactly 8 cycles.
- Loop with stop: len=2 (10,01), hold=1, loop=1 → sequence 10,01,00(GAP),10,01,00…; stop asserted during the second EMIT → IDLE next edge, A=B=0, no done pulse.
- Ignored inputs while busy: during a run, pulse start and issue wr_en to slot 0 → the sequence is unaffected and slot 0 is unchanged after the run. In IDLE, start+stop together and start with len=0 → state remains 00.
- Asynchronous reset mid-run: drive reset low between clock edges during EMIT → A, B and busy drop to 0 and SP=00 without waiting for a clock edge.
